// File: rtl/ldpc_cnu_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_cnu_pkg
//   Shared widths, types and helpers for the serial min-sum check node unit.
//   Contents:
//     - default row degree / widths and the DATA_W derivation
//     - MAG_MAX, the largest representable input magnitude
//     - scale_mode_e : normalized (x3/4) or offset scaling
//     - row_sum_t    : per-row summary {min1, min2, idx, parity, deg}
//   The row-summary struct is sized from the constants below; cnu_serial's
//   width parameters default to them and must be kept in step.
// ---------------------------------------------------------------------------
package ldpc_cnu_pkg;

    localparam int CNU_DMAX  = 32;
    localparam int CNU_RES_W = 8;
    localparam int CNU_EXT_W = 3;
    localparam int CNU_IDX_W = 5;

    function automatic int data_width(input int res_w, input int ext_w);
        return res_w + ext_w;
    endfunction

    localparam int CNU_DATA_W = data_width(CNU_RES_W, CNU_EXT_W);
    localparam int MAG_W      = CNU_DATA_W - 1;
    localparam int DEG_W      = CNU_IDX_W + 1;

    // 2^(DATA_W-1)-1: also the value that saturated -2^(DATA_W-1) maps to.
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic {
        SCALE_NORM   = 1'b0,
        SCALE_OFFSET = 1'b1
    } scale_mode_e;

    typedef struct packed {
        logic [MAG_W-1:0]     min1;
        logic [MAG_W-1:0]     min2;
        logic [CNU_IDX_W-1:0] idx;
        logic                 parity;
        logic [DEG_W-1:0]     deg;
    } row_sum_t;

endpackage

// File: rtl/cnu_row_acc.sv
// ---------------------------------------------------------------------------
// cnu_row_acc
//   Running min1/min2/min1-index/sign-parity accumulator for one row.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     acc_i      one element accepted this cycle
//     init_i     row closes on this element; restart after capturing it
//     mag_i      magnitude of the accepted element
//     sgn_i      sign of the accepted element
//     k_o        position of the element currently presented
//     sum_o      row summary including the presented element (deg = k+1)
// ---------------------------------------------------------------------------
module cnu_row_acc
    import ldpc_cnu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_i,
    input  logic                 init_i,
    input  logic [MAG_W-1:0]     mag_i,
    input  logic                 sgn_i,
    output logic [CNU_IDX_W-1:0] k_o,
    output row_sum_t             sum_o
);

    logic [MAG_W-1:0]     min1_q, min2_q, min1_d, min2_d;
    logic [CNU_IDX_W-1:0] idx_q, idx_d, k_q;
    logic                 par_q, par_d;

    // Strict comparisons: on a tie the earlier element keeps min1 and idx.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        min1_d = min1_q;
        min2_d = min2_q;
        idx_d  = idx_q;
        if (mag_i < min1_q) begin
            min2_d = min1_q;
            min1_d = mag_i;
            idx_d  = k_q;
        end else if (mag_i < min2_q) begin
            min2_d = mag_i;
        end
        par_d = par_q ^ sgn_i;
    end

    assign k_o   = k_q;
    assign sum_o = '{min1:   min1_d,
                     min2:   min2_d,
                     idx:    idx_d,
                     parity: par_d,
                     deg:    {1'b0, k_q} + DEG_W'(1)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min1_q <= MAG_MAX;
            min2_q <= MAG_MAX;
            idx_q  <= '0;
            par_q  <= 1'b0;
            k_q    <= '0;
        end else if (acc_i) begin
            // NOTE: non-blocking so every register sees pre-edge values.
            if (init_i) begin
                min1_q <= MAG_MAX;
                min2_q <= MAG_MAX;
                idx_q  <= '0;
                par_q  <= 1'b0;
                k_q    <= '0;
            end else begin
                min1_q <= min1_d;
                min2_q <= min2_d;
                idx_q  <= idx_d;
                par_q  <= par_d;
                k_q    <= k_q + CNU_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/cnu_serial.sv
// ---------------------------------------------------------------------------
// cnu_serial
//   Serial min-sum check node unit with two ping-pong row slots: one row
//   accumulates while the previous one drains, one message per cycle.
//   Optional feature: define CNU_OFFSET_EN to compile in offset scaling
//   (mode/beta functional). Without it mode/beta are ignored and only the
//   normalized x3/4 path exists.
//   Ports:
//     clk, rst               clock, asynchronous active-low reset
//     in_valid/in_ready      input handshake
//     in_data, in_last       signed q message, last element of row
//     out_valid/out_ready    output handshake (registered outputs)
//     out_data, out_last     signed r message, last element of drained row
//     mode, beta             scaling select and offset magnitude
//     deg_err                sticky: a row was force-closed at DMAX elements
// ---------------------------------------------------------------------------
module cnu_serial
    import ldpc_cnu_pkg::*;
#(
    parameter int  DMAX   = CNU_DMAX,
    parameter int  RES_W  = CNU_RES_W,
    parameter int  EXT_W  = CNU_EXT_W,
    parameter int  IDX_W  = CNU_IDX_W,
    localparam int DATA_W = data_width(RES_W, EXT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    input  logic              mode,
    input  logic [DATA_W-2:0] beta,
    output logic              deg_err
);

    localparam int RMAX = 2 ** (RES_W - 1) - 1;

    logic [1:0]       full_q, full_d;
    logic             wptr_q, rptr_q, fptr_q;   // write, release, feed slot
    logic [IDX_W-1:0] j_q;                      // next element to feed
    logic             deg_err_q;
    logic             out_valid_q, out_last_q;
    logic [RES_W-1:0] out_data_q;
    row_sum_t         slot_q [2];
    logic [DMAX-1:0]  sgn_q  [2];

    logic             accept, at_dmax, commit, forced, release_slot;
    logic [MAG_W-1:0] in_mag;
    logic [IDX_W-1:0] acc_k;
    row_sum_t         acc_sum;

    assign in_ready     = ~full_q[wptr_q];
    assign accept       = in_valid & in_ready;
    assign at_dmax      = (acc_k == IDX_W'(DMAX - 1));
    assign commit       = accept & (in_last | at_dmax);
    assign forced       = accept & ~in_last & at_dmax;
    assign release_slot = out_valid_q & out_ready & out_last_q;

    // |in_data|, with the most negative code folded onto MAG_MAX.
    always_comb begin
        in_mag = in_data[MAG_W-1:0];
        if (in_data[DATA_W-1]) begin
            if (in_data[MAG_W-1:0] == '0) in_mag = MAG_MAX;
            else                          in_mag = ~in_data[MAG_W-1:0] + MAG_W'(1);
        end
    end

    cnu_row_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .acc_i  (accept),
        .init_i (commit),
        .mag_i  (in_mag),
        .sgn_i  (in_data[DATA_W-1]),
        .k_o    (acc_k),
        .sum_o  (acc_sum)
    );

    // Commit and release always target different slots, so both may land
    // on the same edge.
    always_comb begin
        full_d = full_q;
        if (commit)       full_d[wptr_q] = 1'b1;
        if (release_slot) full_d[rptr_q] = 1'b0;
    end

    // ---- output path: element j_q of the feed slot -----------------------
    row_sum_t         fsum;
    logic             load_en, feed, feed_last, neg;
    logic [MAG_W-1:0] m_sel;
    logic [MAG_W+1:0] s_norm, s_val;
    logic [RES_W-1:0] sat_mag, res_d;

    assign fsum      = slot_q[fptr_q];
    assign load_en   = ~out_valid_q | out_ready;
    assign feed      = load_en & full_q[fptr_q];
    assign feed_last = ({1'b0, j_q} == fsum.deg - DEG_W'(1));

    always_comb begin
        m_sel  = (j_q == fsum.idx) ? fsum.min2 : fsum.min1;
        // 3*m / 4 as m + 2m; m is non-negative so a logical shift suffices.
        s_norm = ({2'b00, m_sel} + {1'b0, m_sel, 1'b0}) >> 2;
`ifdef CNU_OFFSET_EN
        if (scale_mode_e'(mode) == SCALE_OFFSET)
            s_val = (m_sel > beta) ? {2'b00, m_sel - beta} : '0;
        else
            s_val = s_norm;
`else
        s_val = s_norm;
`endif
        sat_mag = (s_val > (MAG_W + 2)'(RMAX)) ? RES_W'(RMAX) : s_val[RES_W-1:0];
        neg     = fsum.parity ^ sgn_q[fptr_q][j_q];
        res_d   = neg ? -sat_mag : sat_mag;
    end

`ifndef CNU_OFFSET_EN
    logic unused_cfg;
    assign unused_cfg = ^{mode, beta};
`endif

    // ---- control state ---------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q      <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            fptr_q      <= 1'b0;
            j_q         <= '0;
            deg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q <= full_d;
            if (commit)       wptr_q <= ~wptr_q;
            if (release_slot) rptr_q <= ~rptr_q;
            if (forced)       deg_err_q <= 1'b1;
            if (load_en) begin
                out_valid_q <= full_q[fptr_q];
                out_last_q  <= feed & feed_last;
                if (feed) begin
                    out_data_q <= res_d;
                    j_q        <= feed_last ? '0 : j_q + IDX_W'(1);
                    // Move on once the last element is in the output
                    // register, so the next row follows without a bubble.
                    if (feed_last) fptr_q <= ~fptr_q;
                end
            end
        end
    end

    // ---- slot storage ----------------------------------------------------
    // NOTE: storage needs no reset; full_q gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) sgn_q[wptr_q][acc_k] <= in_data[DATA_W-1];
        if (commit) slot_q[wptr_q]       <= acc_sum;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign deg_err   = deg_err_q;

endmodule

// File: tb/tb_cnu_serial.sv
module tb_cnu_serial;

    localparam int DMAX   = 32;
    localparam int DATA_W = 11;
    localparam int RES_W  = 8;
    localparam int MAGMAX = 1023;
    localparam int RMAX   = 127;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_last;
    logic [RES_W-1:0]  out_data;
    logic              mode;
    logic [DATA_W-2:0] beta;
    logic              deg_err;

    always #5 clk = ~clk;

    cnu_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mode      (mode),
        .beta      (beta),
        .deg_err   (deg_err)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   row_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   cur_mode = 0;
    int   cur_beta = 0;
    int   exp_deg_err = 0;
    bit   rand_ready = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int mag_of(input int x);
        if (x < 0) return (x == -1024) ? MAGMAX : -x;
        return x;
    endfunction

    function automatic bit offset_active();
`ifdef CNU_OFFSET_EN
        return cur_mode;
`else
        return 1'b0;
`endif
    endfunction

    // Extrinsic min-sum: each output uses the smallest magnitude and the
    // sign product of all *other* elements of its row.
    function automatic void model_row();
        int n = row_q.size();
        for (int j = 0; j < n; j++) begin
            int m = MAGMAX;
            bit s = 1'b0;
            int v;
            for (int i = 0; i < n; i++) begin
                if (i != j) begin
                    if (mag_of(row_q[i]) < m) m = mag_of(row_q[i]);
                    s ^= (row_q[i] < 0);
                end
            end
            if (offset_active()) v = (m > cur_beta) ? m - cur_beta : 0;
            else                 v = (3 * m) / 4;
            if (v > RMAX) v = RMAX;
            sb.push_back('{s ? -v : v, j == n - 1});
        end
        row_q.delete();
    endfunction

    task automatic send(input int d, input bit last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d[DATA_W-1:0];
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
        end else begin
            @(posedge clk);
            row_q.push_back(d);
            if (row_q.size() == DMAX && !last) exp_deg_err = 1;
            if (last || row_q.size() == DMAX) model_row();
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks
    // that a stalled output stays put.
    bit stall = 1'b0;
    int h_data;
    int h_last;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_data", int'($signed(out_data)), h_data);
                    check("hold_last", int'(out_last), h_last);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_out: data %0d with empty scoreboard",
                                 $signed(out_data));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("out_data", int'($signed(out_data)), e.data);
                        check("out_last", int'(out_last), int'(e.last));
                    end
                    stall = 1'b0;
                end else if (out_valid) begin
                    stall  = 1'b1;
                    h_data = int'($signed(out_data));
                    h_last = int'(out_last);
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b0;
        beta      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_deg_err", int'(deg_err), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic row with latency check
        send(5, 0); send(-3, 0); send(7, 0); send(2, 1);
        check("t1_lat_edge0", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("t1_lat_edge1", int'(out_valid), 1);
        wait_drain("t1");

        // Tie on the minimum
        send(4, 0); send(4, 0); send(9, 1);
        wait_drain("t2");

        // Offset mode (normalized when the feature is compiled out)
        mode = 1'b1; beta = 10'd1; cur_mode = 1'b1; cur_beta = 1;
        send(6, 0); send(-2, 0); send(3, 1);
        wait_drain("t3");
        mode = 1'b0; beta = '0; cur_mode = 1'b0; cur_beta = 0;

        // Back-to-back rows under back-pressure
        out_ready = 1'b0;
        send(1, 0); send(-8, 0); send(3, 1);
        send(10, 0); send(20, 0); send(-30, 1);
        check("t4_in_ready_low", int'(in_ready), 0);
        repeat (20) @(posedge clk);
        #1;
        check("t4_stalled_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_no_bubble", int'(out_valid), 1);
        end
        wait_drain("t4");
        check("t4_in_ready_back", int'(in_ready), 1);

        // DMAX+1 elements without in_last
        for (int i = 0; i < DMAX; i++) begin
            send(int'($urandom_range(0, 2047)) - 1024, 0);
            if (i == DMAX - 2) check("t5_deg_err_before", int'(deg_err), exp_deg_err);
        end
        check("t5_deg_err_after", int'(deg_err), exp_deg_err);
        send(-17, 0); send(40, 1);
        wait_drain("t5");

        // Most negative input alone
        send(-1024, 1);
        wait_drain("t6");

        // Reset mid-drain
        out_ready = 1'b0;
        send(5, 0); send(6, 0); send(7, 0); send(8, 0); send(9, 1);
        @(posedge clk);
        #1;
        check("t7_valid_before_rst", int'(out_valid), 1);
        #2;
        rst = 1'b0;
        sb.delete();
        row_q.delete();
        exp_deg_err = 0;
        #1;
        check("t7_rst_out_valid", int'(out_valid), 0);
        check("t7_rst_out_data", int'(out_data), 0);
        check("t7_rst_out_last", int'(out_last), 0);
        check("t7_rst_in_ready", int'(in_ready), 1);
        check("t7_rst_deg_err", int'(deg_err), exp_deg_err);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Randomized rows with random back-pressure
`ifdef CNU_OFFSET_EN
        cur_mode = 1'($urandom_range(0, 1));
        cur_beta = int'($urandom_range(0, 40));
        mode     = cur_mode;
        beta     = 10'(cur_beta);
`endif
        rand_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            int len;
            len = int'($urandom_range(1, DMAX));
            for (int i = 0; i < len; i++) begin
                int d;
                if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 2047)) - 1024;
                else                           d = int'($urandom_range(0, 80)) - 40;
                send(d, i == len - 1);
            end
        end
        wait_drain("t8");
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        check("t8_deg_err", int'(deg_err), exp_deg_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cnu_serial.md
Name: cnu_serial

Overview:
- Serial, parametrised min-sum check node unit for row-layered LDPC decoding. It accepts one variable-to-check message per cycle, up to DMAX per row, with row length set at run time by in_last.
- It tracks min1, min2, the min1 index and the sign parity, then emits one scaled, saturated check-to-variable message per cycle.
- Two row slots (ping-pong) let row n+1 accumulate while row n drains.
- It sits between the variable-node message memory and the LLR update adders.

Parameters:
- DMAX, 32, maximum row degree.
- RES_W, 8, output message width (signed).
- EXT_W, 3, extra input precision bits; DATA_W = RES_W + EXT_W.
- IDX_W, 5, index width; must satisfy 2^IDX_W >= DMAX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input message valid.
- in_ready  out  1  accumulator can accept.
- in_data  in  DATA_W  signed two's-complement q message.
- in_last  in  1  final element of the row.
- out_valid  out  1  output message valid.
- out_ready  in  1  downstream accepts.
- out_data  out  RES_W  signed r message.
- out_last  out  1  final element of the drained row.
- mode  in  1  0 = normalized (x3/4), 1 = offset.
- beta  in  DATA_W-1  offset magnitude (offset mode only).
- deg_err  out  1  sticky: a row exceeded DMAX.

Behaviour:
- Reset (rst=0, async):
  - Both slots empty, accumulator cleared, write/read slot pointers 0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, deg_err=0.
  - Applies mid-row or mid-drain; partial data is discarded.
- Input accept: in_valid & in_ready.
  - mag = |in_data|; -2^(DATA_W-1) maps to 2^(DATA_W-1)-1.
  - sgn = in_data MSB, stored at position k of the write slot.
  - The running parity XORs sgn.
- Min update:
  - mag < min1: min2 <= min1, min1 <= mag, idx <= k.
  - else if mag < min2: min2 <= mag.
  - Ties never move idx; first occurrence wins.
  - min1 and min2 initialise to MAG_MAX at row start.
- Row commit:
  - Triggered by an accepted in_last, or by an accepted element at k = DMAX-1 without in_last. The forced case sets deg_err.
  - Slot stores {min1, min2, idx, parity, deg = k+1, signs}; slot full <= 1; write pointer toggles; accumulator reinitialises the same edge.
- in_ready = ~full[wptr]. Both slots full stalls the input. There is no combinational path from out_ready to in_ready except through slot release.
- Output phase:
  - out_valid is registered, asserted the cycle after the slot becomes full. First output latency is 1 cycle after the in_last handshake.
  - Element j: m = (j == idx) ? min2 : min1.
  - Normalized: s = (3*m) >>> 2, arithmetic on DATA_W+2 bits.
  - Offset: s = max(m - beta, 0).
  - Sign = parity ^ sgn[j]. Value = sign ? -s : s, saturated to ±(2^(RES_W-1)-1).
  - Hold: out_data, out_valid and out_last stay stable while out_valid & ~out_ready.
  - out_last = (j == deg-1). Its handshake clears full[rptr] and toggles rptr. The next slot's first output follows on the next cycle (no bubble).
- Degree 1: min2 = MAG_MAX, so the output saturates to ±max.
- Simultaneous commit into one slot and release of the other in the same cycle: both take effect.
- mode and beta are sampled per output element. They must be held constant across a row.

Optional Feature:
- Macro: CNU_OFFSET_EN.
- Defined: the offset path is compiled in and the mode/beta ports are functional.
- Undefined: ports remain but are ignored; normalized x3/4 only. Saves the subtractor and mux.

Decomposition:
- Package ldpc_cnu_pkg holds:
  - DATA_W derivation.
  - MAG_MAX = 2^(DATA_W-1)-1.
  - The scale-mode enum (SCALE_NORM, SCALE_OFFSET).
  - The row-summary struct {min1, min2, idx, parity, deg}.
- Sub-module cnu_row_acc: the per-row min1/min2/idx/parity accumulator with init/commit strobes.
- cnu_serial holds slots, pointers, handshakes, the output scaling path and saturation.

Test Plan:
- Row q = {5, -3, 7, 2} (normalized, out_ready=1):
  - min1=2 at idx 3, min2=3, parity=1.
  - out = {-1, 1, -1, -2}; out_last on the 4th; first out_valid 1 cycle after in_last.
- Tie row {4, 4, 9}:
  - idx=0, min2=4.
  - out = {3, 3, 3}.
- Offset mode, beta=1, row {6, -2, 3}:
  - out = {-1, 2, -1}.
  - With CNU_OFFSET_EN undefined, the same stimulus gives normalized {-1, 2, -1}.
- Back-to-back rows with out_ready=0 for 20 cycles:
  - in_ready drops after the second in_last.
  - Outputs hold stable.
  - Both rows drain in order once out_ready=1, with no bubble.
- Row of DMAX+1 elements without in_last:
  - Commit at element DMAX; deg_err=1.
  - The extra element starts a new row.
- Input -1024 (DATA_W=11) alone in a row:
  - Magnitude 1023; the output saturates to ±127.
  - Assert rst=0 mid-drain: outputs are 0 immediately and in_ready=1.
